// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128 encryptor, RPC unrolled rounds per cycle; define AES_EARLY_ACCEPT_EN for same-edge consume/accept
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p, t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      p = z[i] ? p ^ t : p;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, inv;
  assign a2   = gm(a, a);
  assign a3   = gm(a2, a);
  assign a6   = gm(a3, a3);
  assign a12  = gm(a6, a6);
  assign a15  = gm(a12, a3);
  assign a30  = gm(a15, a15);
  assign a60  = gm(a30, a30);
  assign a120 = gm(a60, a60);
  assign a240 = gm(a120, a120);
  assign inv  = gm(gm(a240, a12), a2);
  assign y    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_enc_iter #(
  parameter int RPC   = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_key,
  input  logic [127:0]     in_pt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_ct,
  output logic [TAG_W-1:0] out_tag
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;
  localparam logic [3:0] LAST = 4'(11 - RPC);
  localparam logic [3:0] STEP = 4'(RPC);
  if (RPC != 1 && RPC != 2 && RPC != 5 && RPC != 10) begin : g_bad_rpc
    $error("aes_enc_iter: RPC must be 1, 2, 5 or 10");
  end
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  fsm_t fsm_q, fsm_d;
  logic [127:0] state_q, state_d, rkey_q, rkey_d;
  logic [3:0] rnd_q, rnd_d;
  logic [7:0] rcon_q, rcon_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [127:0] st [RPC+1];
  logic [127:0] rk [RPC+1];
  logic [7:0] rc [RPC+1];
  logic accept;
  assign st[0] = state_q;
  assign rk[0] = rkey_q;
  assign rc[0] = rcon_q;
  for (genvar r = 0; r < RPC; r++) begin : g_rnd
    logic [127:0] sb, sr, mc;
    logic [31:0] kw, w0, w1, w2, w3;
    for (genvar b = 0; b < 16; b++) begin : g_byte
      aes_sbox u_sb (.a(st[r][127-8*b -: 8]), .y(sb[127-8*b -: 8]));
      assign sr[127-8*b -: 8] = sb[127-8*(b%4 + 4*((b/4 + b%4)%4)) -: 8];
    end
    for (genvar b = 0; b < 4; b++) begin : g_col
      assign mc[127-32*b -: 32] = mix(sr[127-32*b -: 32]);
      aes_sbox u_ks (.a(rk[r][31-8*((b+1)%4) -: 8]), .y(kw[31-8*b -: 8]));
    end
    assign w0 = rk[r][127:96] ^ kw ^ {rc[r], 24'h0};
    assign w1 = rk[r][95:64] ^ w0;
    assign w2 = rk[r][63:32] ^ w1;
    assign w3 = rk[r][31:0] ^ w2;
    assign rk[r+1] = {w0, w1, w2, w3};
    assign rc[r+1] = xt(rc[r]);
    assign st[r+1] = ((rnd_q + 4'(r)) == 4'd10 ? sr : mc) ^ rk[r+1];
  end
`ifdef AES_EARLY_ACCEPT_EN
  assign in_ready = fsm_q == IDLE || (fsm_q == DONE && out_ready);
`else
  assign in_ready = fsm_q == IDLE;
`endif
  assign accept    = in_valid && in_ready;
  assign out_valid = fsm_q == DONE;
  assign out_ct    = state_q;
  assign out_tag   = tag_q;
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    tag_d   = tag_q;
    if (accept) begin
      fsm_d   = BUSY;
      state_d = in_pt ^ in_key;
      rkey_d  = in_key;
      rnd_d   = 4'd1;
      rcon_d  = 8'h01;
      tag_d   = in_tag;
    end else if (fsm_q == BUSY) begin
      fsm_d   = rnd_q == LAST ? DONE : BUSY;
      state_d = st[RPC];
      rkey_d  = rk[RPC];
      rnd_d   = rnd_q + STEP;
      rcon_d  = rc[RPC];
    end else if (fsm_q == DONE && out_ready) begin
      fsm_d   = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rkey_q  <= '0;
      rnd_q   <= '0;
      rcon_q  <= '0;
      tag_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rkey_q  <= rkey_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      tag_q   <= tag_d;
    end
  end
endmodule

// File: tb/tb_aes_enc_iter.sv
// tb_aes_enc_iter: directed and randomized checks of aes_enc_iter against a byte-level AES-128 model
module tb_aes_enc_iter;
  localparam int RPC   = 1;
  localparam int TAG_W = 4;
  localparam int LAT   = 10 / RPC;
`ifdef AES_EARLY_ACCEPT_EN
  localparam int SPACING = LAT + 1;
`else
  localparam int SPACING = LAT + 2;
`endif
  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [127:0] in_key = '0, in_pt = '0, out_ct;
  logic [TAG_W-1:0] in_tag = '0, out_tag;
  logic [7:0] sbox [256];
  int checks = 0, fails = 0;
  aes_enc_iter #(.RPC(RPC), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_pt(in_pt),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct), .out_tag(out_tag)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] s [16];
    logic [7:0] u [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] ct;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = {sbox[t[23:16]] ^ RCON[i/4-1], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]};
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) u[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = u[4*((c+row)%4)+row];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
          s[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic accept_block(input logic [127:0] k, input logic [127:0] p, input logic [TAG_W-1:0] t);
    int n;
    in_key = k;
    in_pt = p;
    in_tag = t;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("accept_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask
  task automatic wait_out(input bit scramble, output int cyc);
    cyc = 0;
    do begin
      if (scramble) begin
        in_key = rand128();
        in_pt = rand128();
        in_tag = TAG_W'($urandom);
      end
      tick();
      cyc++;
    end while (!out_valid && cyc < 200);
    check("out_valid_seen", out_valid, 1'b1);
  endtask
  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("consume_out_valid", out_valid, 1'b0);
    check("consume_in_ready", in_ready, 1'b1);
  endtask
  initial begin
    logic [7:0] b, s, aff;
    logic [127:0] k, p, exp;
    logic [127:0] bk [8];
    logic [127:0] bp [8];
    logic [127:0] bexp [8];
    logic [TAG_W-1:0] tg;
    int cyc, nsent, nrecv, last, seen;
    bit acc, xfer;
    aff = 8'h63;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      for (int i = 0; i < 8; i++) s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ aff[i];
      sbox[x] = s;
    end
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ct", out_ct, 128'h0);
    check("rst_out_tag", out_tag, 4'h0);
    rst = 1'b0;
    k = 128'h000102030405060708090a0b0c0d0e0f;
    p = 128'h00112233445566778899aabbccddeeff;
    accept_block(k, p, 4'h5);
    wait_out(1'b0, cyc);
    check("c1_latency", 128'(cyc), 128'(LAT));
    check("c1_ct", out_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("c1_ct_model", out_ct, aes_ref(k, p));
    check("c1_tag", out_tag, 4'h5);
    consume();
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    p = 128'h3243f6a8885a308d313198a2e0370734;
    accept_block(k, p, 4'hA);
    wait_out(1'b1, cyc);
    check("appb_latency", 128'(cyc), 128'(LAT));
    check("appb_ct", out_ct, 128'h3925841d02dc09fbdc118597196a0b32);
    check("appb_tag", out_tag, 4'hA);
    consume();
    k = rand128();
    p = rand128();
    exp = aes_ref(k, p);
    accept_block(k, p, 4'h3);
    wait_out(1'b1, cyc);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'(i % 2);
      in_key = rand128();
      in_pt = rand128();
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_ct", out_ct, exp);
      check("bp_out_tag", out_tag, 4'h3);
      check("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    consume();
    repeat (3) tick();
    check("bp_no_dup", out_valid, 1'b0);
    check("bp_idle", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      bk[i] = rand128();
      bp[i] = rand128();
      bexp[i] = aes_ref(bk[i], bp[i]);
    end
    nsent = 0;
    nrecv = 0;
    cyc = 0;
    last = 0;
    in_key = bk[0];
    in_pt = bp[0];
    in_tag = '0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (nrecv < 8 && cyc < 500) begin
      acc = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        check("b2b_ct", out_ct, bexp[nrecv]);
        check("b2b_tag", 128'(out_tag), 128'(nrecv));
        if (nrecv > 0) check("b2b_spacing", 128'(cyc - last), 128'(SPACING));
        last = cyc;
        nrecv++;
      end
      tick();
      cyc++;
      if (acc) begin
        nsent++;
        if (nsent < 8) begin
          in_key = bk[nsent];
          in_pt = bp[nsent];
          in_tag = TAG_W'(nsent);
        end else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    check("b2b_count", 128'(nrecv), 128'd8);
    check("b2b_sent", 128'(nsent), 128'd8);
    tick();
    check("b2b_idle", in_ready, 1'b1);
    accept_block(rand128(), rand128(), 4'h7);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_out_ct", out_ct, 128'h0);
    check("abort_out_tag", out_tag, 4'h0);
    seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      if (out_valid) seen++;
      tick();
    end
    out_ready = 1'b0;
    check("abort_no_output", 128'(seen), 128'd0);
    k = 128'h000102030405060708090a0b0c0d0e0f;
    p = 128'h00112233445566778899aabbccddeeff;
    accept_block(k, p, 4'hC);
    wait_out(1'b1, cyc);
    check("c1b_latency", 128'(cyc), 128'(LAT));
    check("c1b_ct", out_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("c1b_tag", out_tag, 4'hC);
    consume();
    for (int n = 0; n < 4; n++) begin
      k = rand128();
      p = rand128();
      tg = TAG_W'($urandom);
      accept_block(k, p, tg);
      wait_out(1'b1, cyc);
      check("rnd_latency", 128'(cyc), 128'(LAT));
      check("rnd_ct", out_ct, aes_ref(k, p));
      check("rnd_tag", out_tag, tg);
      consume();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
